cpu_mult_sequencer: RTL
=======================

Name: cpu_mult_sequencer

Overview:
- Issue/collect stage wrapped around the CPU 16x16 multiply cell.
- Takes one 32x32 multiply request from the execute stage and drives the cell's operand and enable inputs.
- Captures the cell's three partial products: p1 = lo*lo, p2 = src1lo*src2hi, p3 = src1hi*src2lo. For high-word ops it runs a second pass to get hi*hi.
- Combines the partials into the 32-bit MUL/MULXUU/MULXSU/MULXSS result and hands it back with a done pulse.

Parameters:
- CELL_LATENCY, 1: cycles from a cell_en-high issue cycle to valid cell_p1..p3. Legal range 1..3.

Ports:
- clk, input, 1: single clock.
- reset, input, 1: synchronous, active-high reset.
- start, input, 1: request strobe. Sampled only in IDLE.
- op, input, 2: 0=MUL (low word), 1=MULXUU, 2=MULXSU (src1 signed, src2 unsigned), 3=MULXSS.
- src1, input, 32: operand A.
- src2, input, 32: operand B.
- flush, input, 1: synchronous abort of the request in flight.
- cell_src1, output, 32: operand A to the multiply cell (registered).
- cell_src2, output, 32: operand B to the multiply cell (registered).
- cell_en, output, 1: multiply cell enable (registered).
- cell_p1, input, 32: partial product lo*lo from the cell.
- cell_p2, input, 32: partial product src1lo*src2hi.
- cell_p3, input, 32: partial product src1hi*src2lo.
- busy, output, 1: high from the cycle after an accepted start until done or abort.
- done, output, 1: one-cycle pulse; result is valid in the same cycle.
- result, output, 32: product word. Holds its value until the next done.

Behaviour:
- Reset (sync, active-high): state=IDLE; busy, done, cell_en = 0; result, cell_src1, cell_src2 and the captured partial registers = 0.
- Start acceptance: start with state=IDLE latches src1/src2/op into A/B/OP. start while busy is ignored and never queued.
- States: IDLE -> ISSUE1 -> WAIT1 (CELL_LATENCY-1 cycles, skipped when 1) -> CAP1 -> [MUL: FIN] / [MULX: WAIT2 -> CAP2 -> FIN] -> IDLE.
- ISSUE1: cell_src1=A, cell_src2=B, cell_en=1.
  - cell_en stays 1 with operands constant through WAIT1.
  - A down-counter of width clog2(3) tracks the wait.
- CAP1:
  - Capture LL=cell_p1, P2=cell_p2, P3=cell_p3.
  - For MUL, cell_en=0.
  - For MULX ops, in the same cycle: cell_src1={16'h0,A[31:16]}, cell_src2={16'h0,B[31:16]}, cell_en=1, and WAIT2 runs like WAIT1.
- CAP2: capture HH=cell_p1; cell_en=0.
- Arithmetic, all mod 2^32 unless stated:
  - MID = P2+P3, 33 bits.
  - FULL = (HH<<32) + (MID<<16) + LL, 64 bits.
  - MUL: result = LL + (MID[15:0]<<16). HH is not needed.
  - MULXUU: result = FULL[63:32].
  - MULXSU: FULL[63:32] - (A[31] ? B : 0).
  - MULXSS: FULL[63:32] - (A[31] ? B : 0) - (B[31] ? A : 0).
- FIN: result is registered at the end of the last CAP cycle; done=1 and busy=0 in the FIN cycle; next cycle is IDLE.
  - start asserted in the FIN cycle is ignored. Back-to-back issue rate: one accepted start per FIN+1 cycle.
- Latency, with start sampled at cycle 0:
  - MUL: done at cycle 2+CELL_LATENCY.
  - MULX: done at cycle 2+2*CELL_LATENCY.
  - For CELL_LATENCY=1: MUL=3, MULX=4.
- cell_en is 0 in IDLE and FIN, so the cell holds its outputs. Only ISSUE/WAIT/CAP1-of-MULX drive cell_en=1.
- flush in any busy state:
  - Next cycle: state=IDLE, busy=0, cell_en=0, no done pulse, result unchanged.
  - flush together with start in IDLE: start is ignored.
  - flush in the FIN cycle: no effect, done already asserted.
- reset mid-operation: same as the reset values. No done pulse.
- op is latched at start; later changes on op/src1/src2 have no effect.

Decomposition:
- Shared package cpu_mult_pkg:
  - op encoding constants (MUL_OP_MUL, MUL_OP_MULXUU, MUL_OP_MULXSU, MUL_OP_MULXSS);
  - state enum (IDLE, ISSUE1, WAIT1, CAP1, WAIT2, CAP2, FIN);
  - CELL_LATENCY_MAX=3.
- One natural sub-module, cpu_mult_partial_combine: purely combinational LL/P2/P3/HH/A/B/OP -> 32-bit word. The FSM, counters and capture registers stay in the top.

Test Plan:
- MUL, src1=0x00010003, src2=0x00020005, CELL_LATENCY=1 -> cell sees 0x00010003/0x00020005 with cell_en=1 at cycle 1; done at cycle 3; result=0x000B000F.
- MULXUU, 0xFFFFFFFF x 0xFFFFFFFF -> second pass drives 0x0000FFFF/0x0000FFFF at cycle 2; done at cycle 4; result=0xFFFFFFFE.
- MULXSS, 0xFFFFFFFF x 0x00000002 -> result=0xFFFFFFFF. MULXSU, 0x80000000 x 0xFFFFFFFF -> result=0x80000000.
- start re-asserted every cycle during MULXUU, then flush at cycle 2 of a second request -> first request gives exactly one done; second gives no done; busy=0 and cell_en=0 at cycle 3; a new MUL is accepted afterwards and is correct.
- CELL_LATENCY=3, MUL 0x00000007 x 0x00000006 -> cell_en high for cycles 1-3 with stable operands; done at cycle 5; result=0x0000002A.
- reset asserted in CAP1 of MULXSS -> next cycle all outputs 0 and state IDLE; no done ever pulses for that request.

Source files
------------

// File: rtl/cpu_mult_pkg.sv
// rtl/cpu_mult_pkg.sv - shared op encodings, FSM states and limits for the multiply sequencer
package cpu_mult_pkg;

    localparam logic [1:0] MUL_OP_MUL    = 2'd0;
    localparam logic [1:0] MUL_OP_MULXUU = 2'd1;
    localparam logic [1:0] MUL_OP_MULXSU = 2'd2;
    localparam logic [1:0] MUL_OP_MULXSS = 2'd3;

    localparam int CELL_LATENCY_MAX = 3;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE1,
        WAIT1,
        CAP1,
        WAIT2,
        CAP2,
        FIN
    } state_t;

endpackage

// File: rtl/cpu_mult_partial_combine.sv
// rtl/cpu_mult_partial_combine.sv - folds 16x16 partial products into the 32-bit multiply result word
module cpu_mult_partial_combine
    import cpu_mult_pkg::*;
(
    input  logic [31:0] ll,
    input  logic [31:0] p2,
    input  logic [31:0] p3,
    input  logic [31:0] hh,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  op,
    output logic [31:0] word
);

    logic [32:0] mid;
    logic [63:0] full;
    logic [31:0] hi;

    always_comb begin
        mid  = {1'b0, p2} + {1'b0, p3};
        full = {hh, 32'h0} + {15'h0, mid, 16'h0} + {32'h0, ll};
        hi   = full[63:32];
        // Signed high words come from the unsigned product minus the sign corrections.
        case (op)
            MUL_OP_MUL:    word = full[31:0];
            MUL_OP_MULXUU: word = hi;
            MUL_OP_MULXSU: word = hi - (a[31] ? b : 32'h0);
            default:       word = hi - (a[31] ? b : 32'h0) - (b[31] ? a : 32'h0);
        endcase
    end

endmodule

// File: rtl/cpu_mult_sequencer.sv
// rtl/cpu_mult_sequencer.sv - issues 32x32 multiplies to the 16x16 cell and combines its partial products
module cpu_mult_sequencer
    import cpu_mult_pkg::*;
#(
    parameter int CELL_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        flush,
    output logic [31:0] cell_src1,
    output logic [31:0] cell_src2,
    output logic        cell_en,
    input  logic [31:0] cell_p1,
    input  logic [31:0] cell_p2,
    input  logic [31:0] cell_p3,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    localparam int CNT_W = $clog2(CELL_LATENCY_MAX);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(CELL_LATENCY - 2);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic [1:0]       op_q;
    logic [31:0]      ll_q;
    logic [31:0]      p2_q;
    logic [31:0]      p3_q;

    logic        wait_done;
    logic [31:0] ll_in;
    logic [31:0] p2_in;
    logic [31:0] p3_in;
    logic [31:0] comb_word;

    // In CAP1 the live cell outputs feed the combiner so MUL can finish without a second pass.
    always_comb begin
        wait_done = (state == ISSUE1) ? (CELL_LATENCY == 1) : (cnt == '0);
        ll_in     = (state == CAP1) ? cell_p1 : ll_q;
        p2_in     = (state == CAP1) ? cell_p2 : p2_q;
        p3_in     = (state == CAP1) ? cell_p3 : p3_q;
    end

    cpu_mult_partial_combine u_combine (
        .ll   (ll_in),
        .p2   (p2_in),
        .p3   (p3_in),
        .hh   (cell_p1),
        .a    (a_q),
        .b    (b_q),
        .op   (op_q),
        .word (comb_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= MUL_OP_MUL;
            ll_q      <= '0;
            p2_q      <= '0;
            p3_q      <= '0;
            result    <= '0;
            cell_src1 <= '0;
            cell_src2 <= '0;
            cell_en   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (flush && busy) begin
            state   <= IDLE;
            cell_en <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        a_q       <= src1;
                        b_q       <= src2;
                        op_q      <= op;
                        cell_src1 <= src1;
                        cell_src2 <= src2;
                        cell_en   <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ISSUE1;
                    end
                end
                ISSUE1, WAIT1: begin
                    if (wait_done) begin
                        state <= CAP1;
                        // MULX launches the hi*hi pass so it lands while CAP1 is being captured.
                        if (op_q == MUL_OP_MUL) begin
                            cell_en <= 1'b0;
                        end else begin
                            cell_src1 <= {16'h0, a_q[31:16]};
                            cell_src2 <= {16'h0, b_q[31:16]};
                            cell_en   <= 1'b1;
                        end
                    end else if (state == ISSUE1) begin
                        state <= WAIT1;
                        cnt   <= WAIT_LOAD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                CAP1: begin
                    ll_q <= cell_p1;
                    p2_q <= cell_p2;
                    p3_q <= cell_p3;
                    if (op_q == MUL_OP_MUL) begin
                        result <= comb_word;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= FIN;
                    end else if (CELL_LATENCY == 1) begin
                        cell_en <= 1'b0;
                        state   <= CAP2;
                    end else begin
                        cnt   <= WAIT_LOAD;
                        state <= WAIT2;
                    end
                end
                WAIT2: begin
                    if (cnt == '0) begin
                        cell_en <= 1'b0;
                        state   <= CAP2;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                CAP2: begin
                    result <= comb_word;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= FIN;
                end
                FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
